// File: rtl/dmem_if.sv
// Request/response bus between a CPU load/store unit and the data-memory controller.
interface dmem_if #(
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-addressed little-endian word array with
// word/half/byte stores, sign/zero-extended loads, programmable wait states
// and misaligned / out-of-range / reserved-size error reporting.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        rdy_q, rdy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Array storage; contents deliberately survive reset.
  logic [31:0] mem_q [DEPTH_WORDS];
  logic              mem_we_d;
  logic [3:0]        mem_be_d;
  logic [31:0]       mem_wdata_d;
  logic [MEM_AW-1:0] mem_idx_d;

  req_t        cur;
  logic [31:0] cur_idx32;
  logic [1:0]  lane;
  logic        err;
  logic [31:0] mem_rd;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_val;

  // Decode the access being committed. In IDLE the live inputs are used so a
  // zero-wait access can commit on its own accept edge.
  always_comb begin
    cur       = (state_q == S_IDLE)
                ? {bus.req_we, bus.req_size, bus.req_signed, bus.req_addr, bus.req_wdata}
                : req_q;
    cur_idx32 = 32'(cur.addr[ADDR_W-1:2]);
    lane      = cur.addr[1:0];
    err       = (cur.size == 2'b11) ||
                (cur.size == 2'b01 && cur.addr[0]) ||
                (cur.size == 2'b00 && cur.addr[1:0] != 2'b00) ||
                (cur_idx32 >= DEPTH_WORDS);
    mem_idx_d = cur.addr[MEM_AW+1:2];
    mem_rd    = mem_q[mem_idx_d];
    rd_half   = cur.addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    rd_byte   = mem_rd[{lane, 3'b000} +: 8];
    case (cur.size)
      2'b00:   load_val = mem_rd;
      2'b01:   load_val = {{16{cur.sgn & rd_half[15]}}, rd_half};
      2'b10:   load_val = {{24{cur.sgn & rd_byte[7]}}, rd_byte};
      default: load_val = 32'h0;
    endcase
    case (cur.size)
      2'b00: begin
        mem_be_d    = 4'hF;
        mem_wdata_d = cur.wdata;
      end
      2'b01: begin
        mem_be_d    = cur.addr[1] ? 4'hC : 4'h3;
        mem_wdata_d = {2{cur.wdata[15:0]}};
      end
      default: begin
        mem_be_d    = 4'b0001 << lane;
        mem_wdata_d = {4{cur.wdata[7:0]}};
      end
    endcase
  end

  // Next-state logic for the IDLE/WAIT/RESP sequencer and its registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rdy_d       = rdy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && rdy_q) begin
          req_d = cur;
          rdy_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        rdy_d       = 1'b1;
      end
    endcase
    // Commit on the edge that enters RESP: load sampling and store write.
    if (state_q != S_RESP && state_d == S_RESP) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || cur.we) ? 32'h0 : load_val;
      mem_we_d    = cur.we && !err;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane array write; a reset on the commit edge abandons the store.
  always_ff @(posedge clk) begin
    if (mem_we_d && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_d[b]) mem_q[mem_idx_d][8*b +: 8] <= mem_wdata_d[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a zero-wait instance and a 3-wait instance, each with
// its own expected-response queue drained by an independent monitor.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(13)) b0 ();
  dmem_if #(.ADDR_W(13)) b3 ();

  dmem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(13), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  dmem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(13), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? b0.req_ready : b3.req_ready;
  endfunction

  // Monitors: pop and compare whenever a DUT pulses rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (b0.rsp_valid === 1'b1) begin
      if (q0.size() == 0) chk("dut0 unexpected rsp", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("dut0 rdata", b0.rsp_rdata, e.rd);
        chk("dut0 err", {31'b0, b0.rsp_err}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b3.rsp_valid === 1'b1) begin
      if (q3.size() == 0) chk("dut3 unexpected rsp", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("dut3 rdata", b3.rsp_rdata, e.rd);
        chk("dut3 err", {31'b0, b3.rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Present one request, optionally queue its expected response, and return
  // just after the accept edge.
  task automatic issue(input int sel, input bit push, input bit we, input logic [1:0] sz,
                       input bit sg, input logic [12:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee);
    exp_t e;
    int t;
    e.rd = er;
    e.err = ee;
    @(negedge clk);
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else q3.push_back(e);
    end
    if (sel == 0) begin
      b0.req_valid = 1; b0.req_we = we; b0.req_size = sz;
      b0.req_signed = sg; b0.req_addr = a; b0.req_wdata = wd;
    end else begin
      b3.req_valid = 1; b3.req_we = we; b3.req_size = sz;
      b3.req_signed = sg; b3.req_addr = a; b3.req_wdata = wd;
    end
    t = 0;
    while (rdy(sel) !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready timeout", 32'd0, 32'd1);
    else @(posedge clk);
    #1;
    b0.req_valid = 0;
    b3.req_valid = 0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q0.size() != 0 || q3.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(q0.size() + q3.size()), 32'd0);
  endtask

  initial begin
    int bad;
    b0.req_valid = 0; b0.req_we = 0; b0.req_size = 0; b0.req_signed = 0;
    b0.req_addr = 0; b0.req_wdata = 0;
    b3.req_valid = 0; b3.req_we = 0; b3.req_size = 0; b3.req_signed = 0;
    b3.req_addr = 0; b3.req_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst dut0 ready", {31'b0, b0.req_ready}, 32'd1);
    chk("rst dut0 valid", {31'b0, b0.rsp_valid}, 32'd0);
    chk("rst dut0 rdata", b0.rsp_rdata, 32'h0);
    chk("rst dut0 err", {31'b0, b0.rsp_err}, 32'd0);
    chk("rst dut3 ready", {31'b0, b3.req_ready}, 32'd1);
    chk("rst dut3 valid", {31'b0, b3.rsp_valid}, 32'd0);

    // Zero-wait instance: stores, loads, extension, lanes.
    //        sel push we sz     sg addr      wdata         exp_rdata     err
    issue(0, 1, 1, 2'b00, 0, 13'h010, 32'h12345678, 32'h0,        0);
    issue(0, 1, 0, 2'b00, 0, 13'h010, 32'h0,        32'h12345678, 0);
    issue(0, 1, 1, 2'b10, 0, 13'h011, 32'hAAAAAAFF, 32'h0,        0);
    issue(0, 1, 0, 2'b10, 1, 13'h011, 32'h0,        32'hFFFFFFFF, 0);
    issue(0, 1, 0, 2'b10, 0, 13'h011, 32'h0,        32'h000000FF, 0);
    issue(0, 1, 0, 2'b00, 0, 13'h010, 32'h0,        32'h1234FF78, 0);
    issue(0, 1, 1, 2'b01, 0, 13'h012, 32'h55558001, 32'h0,        0);
    issue(0, 1, 0, 2'b01, 1, 13'h012, 32'h0,        32'hFFFF8001, 0);
    issue(0, 1, 0, 2'b01, 0, 13'h012, 32'h0,        32'h00008001, 0);
    issue(0, 1, 0, 2'b00, 0, 13'h010, 32'h0,        32'h8001FF78, 0);
    issue(0, 1, 0, 2'b10, 1, 13'h013, 32'h0,        32'hFFFFFF80, 0);
    issue(0, 1, 0, 2'b01, 1, 13'h010, 32'h0,        32'h0000FF78 | 32'hFFFF0000, 0);
    // Error cases leave memory untouched.
    issue(0, 1, 1, 2'b00, 0, 13'h000, 32'hA5A5A5A5, 32'h0,        0);
    issue(0, 1, 0, 2'b00, 0, 13'h002, 32'h0,        32'h0,        1);
    issue(0, 1, 1, 2'b01, 0, 13'h013, 32'h0000BEEF, 32'h0,        1);
    issue(0, 1, 1, 2'b11, 0, 13'h000, 32'hFFFFFFFF, 32'h0,        1);
    issue(0, 1, 0, 2'b11, 0, 13'h010, 32'h0,        32'h0,        1);
    issue(0, 1, 1, 2'b00, 0, 13'h1000, 32'h11111111, 32'h0,       1);
    issue(0, 1, 0, 2'b00, 0, 13'h1000, 32'h0,       32'h0,        1);
    issue(0, 1, 0, 2'b00, 0, 13'h000, 32'h0,        32'hA5A5A5A5, 0);
    issue(0, 1, 0, 2'b00, 0, 13'h010, 32'h0,        32'h8001FF78, 0);
    drain("dut0 drain");

    // Three-wait instance: latency and ready profile.
    issue(3, 1, 1, 2'b00, 0, 13'h010, 32'h12345678, 32'h0,        0);
    issue(3, 1, 0, 2'b00, 0, 13'h010, 32'h0,        32'h12345678, 0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk($sformatf("t5 valid c%0d", n), {31'b0, b3.rsp_valid}, {31'b0, (n == 4)});
      chk($sformatf("t5 ready c%0d", n), {31'b0, b3.req_ready}, {31'b0, (n == 5)});
    end
    drain("dut3 drain");

    // Reset mid-WAIT abandons the store without a response.
    issue(3, 1, 1, 2'b00, 0, 13'h020, 32'hCAFEF00D, 32'h0,        0);
    drain("dut3 drain pre-reset");
    issue(3, 0, 1, 2'b00, 0, 13'h020, 32'hDEADBEEF, 32'h0,        0);
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (b3.rsp_valid !== 1'b0) bad++;
    end
    chk("t6 no rsp pulse", 32'(bad), 32'd0);
    chk("t6 ready after rst", {31'b0, b3.req_ready}, 32'd1);
    issue(3, 1, 0, 2'b00, 0, 13'h020, 32'h0,        32'hCAFEF00D, 0);
    issue(3, 1, 0, 2'b01, 0, 13'h022, 32'h0,        32'h0000CAFE, 0);
    drain("final drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
